// File: rtl/timer_pkg.sv
// Shared encodings for the timer run-control slice.
// States, mode selects and interrupt flag bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    TMR_IDLE  = 2'd0,
    TMR_LOAD  = 2'd1,
    TMR_RUN   = 2'd2,
    TMR_PAUSE = 2'd3
  } tmr_state_t;

  localparam logic TMR_MODE_PERIODIC = 1'b0;
  localparam logic TMR_MODE_REPEAT   = 1'b1;

  localparam int ITR_EXPIRE = 0;
  localparam int ITR_DONE   = 1;
  localparam int ITR_NUM    = 2;

endpackage

// File: rtl/basic_timer.sv
// Prescaled down-counter; expired is high in the cycle the
// counter underflows and reloads from autoload.
module basic_timer #(
  parameter int timer_width = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [timer_width-1:0] prescale,
  input  logic [timer_width-1:0] autoload,
  input  logic                   cnt_to_set,
  input  logic [timer_width-1:0] cnt_set_v,
  input  logic                   started,
  output logic                   expired,
  output logic [timer_width-1:0] cnt
);

  logic [timer_width-1:0] pre_cnt;
  logic                   tick;

  assign tick    = started && (pre_cnt == prescale);
  assign expired = tick && (cnt == '0);

  // prescale phase is dropped whenever the timer is not running
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_cnt <= '0;
    end else if (!started || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + timer_width'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (cnt_to_set) begin
      cnt <= cnt_set_v;
    end else if (tick) begin
      cnt <= (cnt == '0) ? autoload : cnt - timer_width'(1);
    end
  end

endmodule

// File: rtl/timer_itr_flags.sv
// Sticky interrupt flags with a one-cycle request pulse.
// Set wins over clear; simultaneous sets give a single pulse.
module timer_itr_flags #(
  parameter int num_flags = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [num_flags-1:0] flag_set,
  input  logic [num_flags-1:0] flag_clr,
  output logic [num_flags-1:0] pending,
  output logic                 req
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending <= '0;
      req     <= 1'b0;
    end else begin
      pending <= (pending & ~flag_clr) | flag_set;
      req     <= |flag_set;
    end
  end

endmodule

// File: rtl/timer_run_ctrl.sv
// Run-control sequencer for one basic_timer: load, run,
// pause/resume, stop, repeat-N counting and interrupt flags.
module timer_run_ctrl
  import timer_pkg::*;
#(
  parameter int timer_width      = 16,
  parameter int rpt_width        = 8,
  parameter int simulation_delay = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [timer_width-1:0] cfg_prescale,
  input  logic [timer_width-1:0] cfg_autoload,
  input  logic                   cfg_mode,
  input  logic [rpt_width-1:0]   cfg_repeat_n,
  input  logic                   cmd_start,
  input  logic                   cmd_stop,
  input  logic                   cmd_pause,
  input  logic                   cmd_resume,
  input  logic [1:0]             itr_clr,
  output logic [timer_width-1:0] tmr_prescale,
  output logic [timer_width-1:0] tmr_autoload,
  output logic                   tmr_cnt_to_set,
  output logic [timer_width-1:0] tmr_cnt_set_v,
  output logic                   tmr_started,
  input  logic                   tmr_expired,
  output logic                   busy,
  output logic                   paused,
  output logic [rpt_width-1:0]   expire_cnt,
  output logic [1:0]             itr_pending,
  output logic                   itr_req
);

  tmr_state_t             state;
  logic                   sh_mode;
  logic [rpt_width-1:0]   remaining;
  logic                   ev_expire;
  logic                   ev_done;
  logic [ITR_NUM-1:0]     itr_set;
  logic                   unused_sim_delay;

  assign unused_sim_delay = (simulation_delay != 0);

  // expiry only counts when no higher-priority command owns the cycle
  always_comb begin
    ev_expire = 1'b0;
    ev_done   = 1'b0;
    if ((state == TMR_RUN) && tmr_expired &&
        !cmd_stop && !cmd_start && !cmd_pause) begin
      ev_expire = 1'b1;
      ev_done   = (sh_mode == TMR_MODE_REPEAT) &&
                  (remaining == '0);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= TMR_IDLE;
      sh_mode        <= TMR_MODE_PERIODIC;
      remaining      <= '0;
      expire_cnt     <= '0;
      tmr_prescale   <= '0;
      tmr_autoload   <= '0;
      tmr_cnt_set_v  <= '0;
      tmr_cnt_to_set <= 1'b0;
      tmr_started    <= 1'b0;
      busy           <= 1'b0;
      paused         <= 1'b0;
    end else begin
      tmr_cnt_to_set <= 1'b0;
      if (cmd_stop) begin
        state       <= TMR_IDLE;
        tmr_started <= 1'b0;
        busy        <= 1'b0;
        paused      <= 1'b0;
      end else if (cmd_start) begin
        state          <= TMR_LOAD;
        sh_mode        <= cfg_mode;
        remaining      <= cfg_repeat_n;
        expire_cnt     <= '0;
        tmr_prescale   <= cfg_prescale;
        tmr_autoload   <= cfg_autoload;
        tmr_cnt_set_v  <= cfg_autoload;
        tmr_cnt_to_set <= 1'b1;
        tmr_started    <= 1'b0;
        busy           <= 1'b1;
        paused         <= 1'b0;
      end else begin
        unique case (state)
          TMR_LOAD: begin
            state       <= TMR_RUN;
            tmr_started <= 1'b1;
          end
          TMR_RUN: begin
            if (cmd_pause) begin
              state       <= TMR_PAUSE;
              tmr_started <= 1'b0;
              paused      <= 1'b1;
            end else if (ev_expire) begin
              expire_cnt <= expire_cnt + rpt_width'(1);
              if (ev_done) begin
                state       <= TMR_IDLE;
                tmr_started <= 1'b0;
                busy        <= 1'b0;
              end else if (sh_mode == TMR_MODE_REPEAT) begin
                remaining <= remaining - rpt_width'(1);
              end
            end
          end
          TMR_PAUSE: begin
            if (cmd_resume) begin
              state       <= TMR_RUN;
              tmr_started <= 1'b1;
              paused      <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign itr_set[ITR_EXPIRE] = ev_expire;
  assign itr_set[ITR_DONE]   = ev_done;

  timer_itr_flags #(
    .num_flags (ITR_NUM)
  ) u_itr_flags (
    .clk      (clk),
    .resetn   (resetn),
    .flag_set (itr_set),
    .flag_clr (itr_clr),
    .pending  (itr_pending),
    .req      (itr_req)
  );

endmodule
